// File: rtl/fm_pkg.sv
// Shared constants for the FM discriminator: CORDIC arctangent table,
// angle helpers and FSM state encoding.
package fm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ITER,
    S_DIFF,
    S_OUT
  } state_e;

  // atan(2^-k) with a full circle equal to 2^32
  function automatic logic [31:0] atan_ref(input int k);
    logic [31:0] a;
    case (k)
      0:       a = 32'h2000_0000;
      1:       a = 32'h12E4_051E;
      2:       a = 32'h09FB_385B;
      3:       a = 32'h0511_11D4;
      4:       a = 32'h028B_0D43;
      5:       a = 32'h0145_D7E1;
      6:       a = 32'h00A2_F61E;
      7:       a = 32'h0051_7C55;
      8:       a = 32'h0028_BE53;
      9:       a = 32'h0014_5F2F;
      10:      a = 32'h000A_2F98;
      11:      a = 32'h0005_17CC;
      12:      a = 32'h0002_8BE6;
      13:      a = 32'h0001_45F3;
      default: a = '0;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] atan_scaled(input int k, input int w);
    return ((atan_ref(k) >> (31 - w)) + 32'd1) >> 1;
  endfunction

  function automatic logic [31:0] half_circle(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fm_cordic_vector.sv
// Iterative CORDIC vectoring: one pre-rotation step into the right
// half plane, then one micro-rotation per clock driving y towards 0.
module fm_cordic_vector
  import fm_pkg::*;
#(
  parameter int IN_W    = 17,
  parameter int ANGLE_W = 16,
  parameter int ITERS   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IN_W-1:0]    i_i,
  input  logic [IN_W-1:0]    i_q,
  output logic               done,
  output logic [IN_W+1:0]    x_o,
  output logic [ANGLE_W-1:0] z_o
);

  localparam int XW = IN_W + 2;
  localparam int KW = $clog2(ITERS + 1);

  logic signed [XW-1:0] x_q, x_d;
  logic signed [XW-1:0] y_q, y_d;
  logic signed [XW-1:0] xs, ys;
  logic [ANGLE_W-1:0]   z_q, z_d;
  logic [ANGLE_W-1:0]   atan_k;
  logic [KW-1:0]        k_q, k_d;
  logic                 pre_q, pre_d;
  logic                 busy_q, busy_d;

  assign atan_k = ANGLE_W'(atan_scaled(int'(k_q), ANGLE_W));
  assign done   = busy_q && (k_q == KW'(ITERS - 1));
  assign x_o    = x_q;
  assign z_o    = z_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    k_d    = k_q;
    pre_d  = 1'b0;
    busy_d = busy_q;
    xs     = x_q >>> k_q;
    ys     = y_q >>> k_q;
    if (start) begin
      x_d    = {{2{i_i[IN_W-1]}}, i_i};
      y_d    = {{2{i_q[IN_W-1]}}, i_q};
      z_d    = '0;
      pre_d  = 1'b1;
      busy_d = 1'b0;
    end else if (pre_q) begin
      if (x_q[XW-1]) begin
        x_d = -x_q;
        y_d = -y_q;
        z_d = ANGLE_W'(half_circle(ANGLE_W));
      end
      k_d    = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // a zero vector has no direction: leave the angle at its seed
      if (x_q != '0 || y_q != '0) begin
        if (y_q[XW-1]) begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_k;
        end else begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_k;
        end
      end
      k_d = k_q + KW'(1);
      if (k_q == KW'(ITERS - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      k_q    <= '0;
      pre_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      k_q    <= k_d;
      pre_q  <= pre_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/fm_discriminator.sv
// FM discriminator: CORDIC phase/magnitude of each I/Q sample, then the
// modulo phase step since the previous sample as the frequency word.
module fm_discriminator
  import fm_pkg::*;
#(
  parameter int IN_W    = 17,
  parameter int PHASE_W = 12,
  parameter int ANGLE_W = 16,
  parameter int ITERS   = 12
) (
  input  logic               i_ref_clk,
  input  logic               i_resetb,
  input  logic               i_clear,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [IN_W-1:0]    i_i,
  input  logic [IN_W-1:0]    i_q,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [PHASE_W-1:0] o_freq,
  output logic [PHASE_W-1:0] o_phase,
  output logic [IN_W+1:0]    o_mag
);

  localparam int SH = ANGLE_W - PHASE_W;

  state_e               state_q, state_d;
  logic                 first_q, first_d;
  logic                 sup_q, sup_d;
  logic                 valid_q, valid_d;
  logic [PHASE_W-1:0]   prev_q, prev_d;
  logic [PHASE_W-1:0]   freq_q, freq_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [IN_W+1:0]      mag_q, mag_d;
  logic [PHASE_W-1:0]   phase_new;
  logic [IN_W+1:0]      cx;
  logic [ANGLE_W-1:0]   cz, zr;
  logic                 accept, done;

  assign o_ready   = (state_q == S_IDLE);
  assign accept    = i_valid & o_ready;
  assign zr        = cz + ANGLE_W'(1 << (SH - 1));
  assign phase_new = PHASE_W'(zr >> SH);
  assign o_valid   = valid_q;
  assign o_freq    = freq_q;
  assign o_phase   = phase_q;
  assign o_mag     = mag_q;

  fm_cordic_vector #(
    .IN_W   (IN_W),
    .ANGLE_W(ANGLE_W),
    .ITERS  (ITERS)
  ) u_cordic (
    .clk  (i_ref_clk),
    .rst_n(i_resetb),
    .start(accept),
    .i_i  (i_i),
    .i_q  (i_q),
    .done (done),
    .x_o  (cx),
    .z_o  (cz)
  );

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    sup_d   = sup_q;
    valid_d = valid_q;
    prev_d  = prev_q;
    freq_d  = freq_q;
    phase_d = phase_q;
    mag_d   = mag_q;
    if (i_clear) first_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        // suppression is decided at accept so a later clear
        // cannot drop the sample already in flight
        if (accept) begin
          sup_d   = first_q | i_clear;
          first_d = 1'b0;
          state_d = S_PRE;
        end
      end
      S_PRE:  state_d = S_ITER;
      S_ITER: if (done) state_d = S_DIFF;
      S_DIFF: begin
        prev_d = phase_new;
        if (!sup_q) begin
          phase_d = phase_new;
          freq_d  = phase_new - prev_q;
          mag_d   = cx;
          valid_d = 1'b1;
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (!valid_q) begin
          state_d = S_IDLE;
        end else if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      state_q <= S_IDLE;
      first_q <= 1'b1;
      sup_q   <= 1'b0;
      valid_q <= 1'b0;
      prev_q  <= '0;
      freq_q  <= '0;
      phase_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      sup_q   <= sup_d;
      valid_q <= valid_d;
      prev_q  <= prev_d;
      freq_q  <= freq_d;
      phase_q <= phase_d;
      mag_q   <= mag_d;
    end
  end

endmodule
